// File: rtl/sample_usb_packer_pkg.sv
// Shared state encoding, sizes and the packed-length helper for the sample-to-USB packer.
package sample_usb_packer_pkg;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StLo    = 2'd1,
      StHi    = 2'd2
   } pack_state_e;

   localparam int unsigned USB_PKT_MAX = 64;
   localparam int unsigned LEN_W       = 7;

   // Bank b's byte count occupies bits [7b+6:7b] of the packed length vector.
   function automatic logic [2*LEN_W-1:0] len_update(input logic [2*LEN_W-1:0] lens,
                                                     input logic               bank,
                                                     input logic [LEN_W-1:0]   len);
      logic [2*LEN_W-1:0] res;
      res = lens;
      if (bank) begin
         res[2*LEN_W-1:LEN_W] = len;
      end else begin
         res[LEN_W-1:0] = len;
      end
      return res;
   endfunction

endpackage

// File: rtl/sample_usb_packer_idle_timer.sv
// Counts FIFO-empty cycles while a partial packet is pending; expired forces a short commit.
module idle_timer #(
   parameter int unsigned TIMEOUT = 48000,
   parameter int unsigned TW      = 16
) (
   input  logic clk_48,
   input  logic rst_n,
   input  logic run,
   input  logic clr,
   output logic expired
);

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt_q;

   // Saturates at LAST so a stalled commit cannot wrap the count back to zero.
   always_ff @(posedge clk_48 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (run && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/sample_usb_packer.sv
// Streams 16-bit readback FIFO words little-endian into two 64-byte USB IN packet banks.
module sample_usb_packer
   import sample_usb_packer_pkg::*;
#(
   parameter int unsigned PKT_BYTES = USB_PKT_MAX,
   parameter int unsigned TIMEOUT   = 48000,
   parameter int unsigned TW        = 16
) (
   input  logic        clk_48,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        flush,
   output logic        fifo_rd,
   input  logic [15:0] fifo_rd_data,
   input  logic        fifo_empty,
   output logic        buf_we,
   output logic [6:0]  buf_addr,
   output logic [7:0]  buf_data,
   output logic [1:0]  pkt_valid,
   output logic [13:0] pkt_len,
   input  logic [1:0]  pkt_release,
   output logic        wr_bank
);

   localparam logic [6:0] PKT_LEN = 7'(PKT_BYTES);

   pack_state_e state_q;
   logic [6:0]  ptr_q;
   logic [7:0]  hi_q;
   logic        wr_bank_q;
   logic [1:0]  pkt_valid_q;
   logic [13:0] pkt_len_q;
   logic        active_q;

   logic [6:0]  ptr_next;
   logic        full_hit;
   logic        can_read;
   logic        short_commit;
   logic        full_commit;
   logic        commit;
   logic [6:0]  commit_len;
   logic [1:0]  bank_mask;
   logic [1:0]  pkt_valid_d;
   logic        idle_run;
   logic        idle_clr;
   logic        idle_expired;

   // active_q keeps the read strobe low for the whole reset and the first cycle after it.
   assign can_read     = active_q && enable && !fifo_empty && !pkt_valid_q[wr_bank_q];
   assign ptr_next     = ptr_q + 7'd2;
   assign full_hit     = (ptr_next == PKT_LEN);

   assign short_commit = (state_q == StFetch) && !can_read && (ptr_q != 7'd0) &&
                         (flush || idle_expired);
   assign full_commit  = (state_q == StHi) && full_hit;
   assign commit       = short_commit || full_commit;
   assign commit_len   = full_commit ? ptr_next : ptr_q;

   assign bank_mask    = wr_bank_q ? 2'b10 : 2'b01;
   assign pkt_valid_d  = (pkt_valid_q & ~pkt_release) | (commit ? bank_mask : 2'b00);

   assign fifo_rd      = can_read &&
                         ((state_q == StFetch) || ((state_q == StHi) && !full_hit));

   assign idle_run     = (ptr_q != 7'd0) && fifo_empty;
   assign idle_clr     = fifo_rd || commit;

   idle_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_idle_timer (
      .clk_48  (clk_48),
      .rst_n   (rst_n),
      .run     (idle_run),
      .clr     (idle_clr),
      .expired (idle_expired)
   );

   // The low byte goes straight from the FIFO data bus; the high byte is held for one cycle.
   always_comb begin
      buf_we   = 1'b0;
      buf_addr = '0;
      buf_data = '0;
      case (state_q)
         StLo: begin
            buf_we   = 1'b1;
            buf_addr = {wr_bank_q, ptr_q[5:0]};
            buf_data = fifo_rd_data[7:0];
         end
         StHi: begin
            buf_we   = 1'b1;
            buf_addr = {wr_bank_q, ptr_q[5:0] + 6'd1};
            buf_data = hi_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFetch;
         ptr_q       <= '0;
         hi_q        <= '0;
         wr_bank_q   <= 1'b0;
         pkt_valid_q <= '0;
         pkt_len_q   <= '0;
         active_q    <= 1'b0;
      end else begin
         active_q    <= 1'b1;
         pkt_valid_q <= pkt_valid_d;
         case (state_q)
            StFetch: begin
               if (can_read) begin
                  state_q <= StLo;
               end
            end
            StLo: begin
               hi_q    <= fifo_rd_data[15:8];
               state_q <= StHi;
            end
            StHi: begin
               ptr_q <= ptr_next;
               if (full_hit) begin
                  state_q <= StFetch;
               end else if (can_read) begin
                  state_q <= StLo;
               end else begin
                  state_q <= StFetch;
               end
            end
            default: state_q <= StFetch;
         endcase
         // A commit always targets the bank being filled, which cannot be valid right now.
         if (commit) begin
            pkt_len_q <= len_update(pkt_len_q, wr_bank_q, commit_len);
            wr_bank_q <= ~wr_bank_q;
            ptr_q     <= '0;
         end
      end
   end

   assign pkt_valid = pkt_valid_q;
   assign pkt_len   = pkt_len_q;
   assign wr_bank   = wr_bank_q;

endmodule

// File: tb/tb_sample_usb_packer.sv
// Self-checking bench: FIFO model plus a write scoreboard filled as words are queued.
module tb_sample_usb_packer;

   localparam int unsigned PKT = 64;
   localparam int unsigned TO  = 100;

   logic        clk_48 = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic        fifo_rd;
   logic [15:0] fifo_rd_data = '0;
   logic        fifo_empty;
   logic        buf_we;
   logic [6:0]  buf_addr;
   logic [7:0]  buf_data;
   logic [1:0]  pkt_valid;
   logic [13:0] pkt_len;
   logic [1:0]  pkt_release = 2'b00;
   logic        wr_bank;

   logic [15:0] mem [0:1023];
   int          n_push = 0;
   int          n_pop = 0;
   int          rd_err = 0;
   int          cyc = 0;
   int          rd_hist[$];
   logic [14:0] sb[$];
   int          exp_ptr = 0;
   logic        exp_bank = 1'b0;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk_48 = ~clk_48;

   sample_usb_packer #(
      .PKT_BYTES (PKT),
      .TIMEOUT   (TO),
      .TW        (16)
   ) dut (
      .clk_48       (clk_48),
      .rst_n        (rst_n),
      .enable       (enable),
      .flush        (flush),
      .fifo_rd      (fifo_rd),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty   (fifo_empty),
      .buf_we       (buf_we),
      .buf_addr     (buf_addr),
      .buf_data     (buf_data),
      .pkt_valid    (pkt_valid),
      .pkt_len      (pkt_len),
      .pkt_release  (pkt_release),
      .wr_bank      (wr_bank)
   );

   assign fifo_empty = (n_push == n_pop);

   // FIFO read side: data appears the cycle after the strobe.
   always @(posedge clk_48) begin
      cyc <= cyc + 1;
      if (fifo_rd) begin
         rd_hist.push_back(cyc);
         if (n_pop >= n_push) begin
            rd_err <= rd_err + 1;
         end else begin
            fifo_rd_data <= mem[n_pop];
            n_pop        <= n_pop + 1;
         end
      end
   end

   task automatic model_commit();
      exp_bank = ~exp_bank;
      exp_ptr  = 0;
   endtask

   task automatic expect_word(input logic [15:0] w);
      sb.push_back({exp_bank, 6'(exp_ptr), w[7:0]});
      sb.push_back({exp_bank, 6'(exp_ptr + 1), w[15:8]});
      exp_ptr += 2;
      if (exp_ptr == PKT) model_commit();
   endtask

   task automatic push_word(input logic [15:0] w);
      mem[n_push] = w;
      n_push++;
      expect_word(w);
   endtask

   // Advance one cycle and check any packet RAM write against the scoreboard.
   task automatic tick();
      logic [14:0] exp;
      @(negedge clk_48);
      if (rst_n && buf_we) begin
         n_chk++;
         if (sb.size() == 0) begin
            $display("FAIL sb_extra_write: got addr %0d data %02h want no write", buf_addr, buf_data);
         end else begin
            exp = sb.pop_front();
            if ({buf_addr, buf_data} !== exp)
               $display("FAIL sb_write: got addr %0d data %02h want addr %0d data %02h",
                        buf_addr, buf_data, exp[14:8], exp[7:0]);
            else n_pass++;
         end
      end
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      enable      = 1'b0;
      flush       = 1'b0;
      pkt_release = 2'b00;
      n_push      = n_pop;
      sb.delete();
      exp_bank = 1'b0;
      exp_ptr  = 0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = (sb.size() == 0) && fifo_empty;
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      push_word(16'h1234);
      tick();
      n_chk++; if (fifo_rd !== 1'b0) $display("FAIL rst_fifo_rd: got %b want 0", fifo_rd); else n_pass++;
      n_chk++; if ({buf_we, buf_addr, buf_data} !== 16'h0)
         $display("FAIL rst_buf: got we %b addr %0d data %02h want 0", buf_we, buf_addr, buf_data);
      else n_pass++;
      n_chk++; if ({pkt_valid, pkt_len, wr_bank} !== 17'h0)
         $display("FAIL rst_pkt: got valid %b len %h bank %b want 0", pkt_valid, pkt_len, wr_bank);
      else n_pass++;
   endtask

   task automatic test_full_packet();
      int first, bad;
      bit ok;
      do_reset();
      first = rd_hist.size();
      for (int i = 0; i < 32; i++) push_word(16'h0100 + 16'(i));
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         ok = pkt_valid[0];
      end
      n_chk++; if (!ok) $display("FAIL fp_commit: got no commit want commit within 200 cycles"); else n_pass++;
      n_chk++; if (pkt_valid !== 2'b01) $display("FAIL fp_valid: got %b want 01", pkt_valid); else n_pass++;
      n_chk++; if (pkt_len[6:0] !== 7'd64) $display("FAIL fp_len0: got %0d want 64", pkt_len[6:0]); else n_pass++;
      n_chk++; if (wr_bank !== 1'b1) $display("FAIL fp_wr_bank: got %b want 1", wr_bank); else n_pass++;
      n_chk++; if (sb.size() != 0) $display("FAIL fp_sb_left: got %0d want 0", sb.size()); else n_pass++;
      n_chk++; if (rd_hist.size() - first != 32)
         $display("FAIL fp_rd_count: got %0d want 32", rd_hist.size() - first);
      else n_pass++;
      bad = 0;
      for (int i = first + 1; i < rd_hist.size(); i++) if (rd_hist[i] - rd_hist[i-1] != 2) bad++;
      n_chk++; if (bad != 0) $display("FAIL fp_rd_spacing: got %0d bad gaps want 0", bad); else n_pass++;
      pkt_release = 2'b01;
      tick();
      pkt_release = 2'b00;
      n_chk++; if (pkt_valid !== 2'b00) $display("FAIL fp_release: got %b want 00", pkt_valid); else n_pass++;
   endtask

   task automatic test_back_pressure();
      int r0;
      bit ok;
      do_reset();
      for (int i = 0; i < 70; i++) push_word(16'h2000 + 16'(i));
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         tick();
         ok = (pkt_valid == 2'b11);
      end
      n_chk++; if (!ok) $display("FAIL bp_both_valid: got %b want 11", pkt_valid); else n_pass++;
      n_chk++; if (pkt_len !== {7'd64, 7'd64}) $display("FAIL bp_len: got %h want %h", pkt_len, {7'd64, 7'd64});
      else n_pass++;
      r0 = rd_hist.size();
      repeat (10) tick();
      n_chk++; if (rd_hist.size() != r0) $display("FAIL bp_stall: got %0d reads want 0", rd_hist.size() - r0);
      else n_pass++;
      n_chk++; if (n_push - n_pop != 6) $display("FAIL bp_fifo_level: got %0d want 6", n_push - n_pop);
      else n_pass++;
      pkt_release = 2'b01;
      tick();
      pkt_release = 2'b00;
      n_chk++; if (pkt_valid !== 2'b10) $display("FAIL bp_release: got %b want 10", pkt_valid); else n_pass++;
      wait_drain(60, ok);
      n_chk++; if (!ok) $display("FAIL bp_resume: got %0d bytes pending want 0", sb.size()); else n_pass++;
      n_chk++; if ({pkt_valid, wr_bank} !== 3'b100)
         $display("FAIL bp_after: got valid %b bank %b want 10/0", pkt_valid, wr_bank);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int commit_edge;
      bit ok;
      do_reset();
      for (int i = 0; i < 3; i++) push_word(16'h3000 + 16'(i));
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         ok = pkt_valid[0];
      end
      commit_edge = cyc - 1;
      n_chk++; if (!ok) $display("FAIL to_commit: got no commit want commit within 300 cycles"); else n_pass++;
      n_chk++; if (commit_edge - rd_hist[$] != TO)
         $display("FAIL to_delay: got %0d want %0d", commit_edge - rd_hist[$], TO);
      else n_pass++;
      n_chk++; if (pkt_len[6:0] !== 7'd6) $display("FAIL to_len0: got %0d want 6", pkt_len[6:0]); else n_pass++;
      n_chk++; if ({pkt_valid, wr_bank} !== 3'b011)
         $display("FAIL to_state: got valid %b bank %b want 01/1", pkt_valid, wr_bank);
      else n_pass++;
      model_commit();
   endtask

   task automatic test_flush();
      bit ok;
      do_reset();
      enable = 1'b1;
      flush  = 1'b1;
      repeat (3) tick();
      n_chk++; if (pkt_valid !== 2'b00) $display("FAIL fl_empty: got %b want 00", pkt_valid); else n_pass++;
      flush = 1'b0;
      push_word(16'hBEEF);
      wait_drain(20, ok);
      n_chk++; if (!ok) $display("FAIL fl_drain: got %0d bytes pending want 0", sb.size()); else n_pass++;
      tick();
      flush = 1'b1;
      tick();
      n_chk++; if ({pkt_valid, wr_bank} !== 3'b011)
         $display("FAIL fl_commit: got valid %b bank %b want 01/1", pkt_valid, wr_bank);
      else n_pass++;
      n_chk++; if (pkt_len[6:0] !== 7'd2) $display("FAIL fl_len0: got %0d want 2", pkt_len[6:0]); else n_pass++;
      model_commit();
      repeat (3) tick();
      n_chk++; if ({pkt_valid, pkt_len[13:7]} !== {2'b01, 7'd0})
         $display("FAIL fl_hold: got valid %b len1 %0d want 01/0", pkt_valid, pkt_len[13:7]);
      else n_pass++;
      flush = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      for (int i = 0; i < 64; i++) push_word(16'h4000 + 16'(i));
      enable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         tick();
         ok = (pkt_valid == 2'b11);
      end
      n_chk++; if (!ok || wr_bank !== 1'b0)
         $display("FAIL bb_fill: got valid %b bank %b want 11/0", pkt_valid, wr_bank);
      else n_pass++;
      pkt_release = 2'b01;
      tick();
      pkt_release = 2'b00;
      push_word(16'h55AA);
      wait_drain(20, ok);
      n_chk++; if (!ok) $display("FAIL bb_drain: got %0d bytes pending want 0", sb.size()); else n_pass++;
      tick();
      flush       = 1'b1;
      pkt_release = 2'b10;
      tick();
      flush       = 1'b0;
      pkt_release = 2'b00;
      n_chk++; if ({pkt_valid, wr_bank} !== 3'b011)
         $display("FAIL bb_swap: got valid %b bank %b want 01/1", pkt_valid, wr_bank);
      else n_pass++;
      n_chk++; if (pkt_len !== {7'd64, 7'd2}) $display("FAIL bb_len: got %h want %h", pkt_len, {7'd64, 7'd2});
      else n_pass++;
      model_commit();
      push_word(16'h6677);
      wait_drain(20, ok);
      n_chk++; if (!ok || {pkt_valid, wr_bank} !== 3'b011)
         $display("FAIL bb_bank1_fill: got valid %b bank %b want 01/1", pkt_valid, wr_bank);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      int r0, first_idx;
      logic [15:0] first_w;
      bit ok, seen;
      do_reset();
      for (int i = 0; i < 8; i++) push_word(16'h5000 + 16'(i * 16'h0111));
      enable = 1'b1;
      r0 = rd_hist.size();
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         ok = (rd_hist.size() - r0 == 5);
      end
      n_chk++; if (!ok || buf_we !== 1'b1) $display("FAIL ar_reach_lo: got we %b want 1", buf_we); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++; if ({fifo_rd, buf_we, buf_addr, buf_data} !== 17'h0)
         $display("FAIL ar_async_buf: got rd %b we %b addr %0d data %02h want 0",
                  fifo_rd, buf_we, buf_addr, buf_data);
      else n_pass++;
      n_chk++; if ({pkt_valid, pkt_len, wr_bank} !== 17'h0)
         $display("FAIL ar_async_pkt: got valid %b len %h bank %b want 0", pkt_valid, pkt_len, wr_bank);
      else n_pass++;
      sb.delete();
      exp_bank  = 1'b0;
      exp_ptr   = 0;
      first_idx = n_pop;
      for (int i = n_pop; i < n_push; i++) expect_word(mem[i]);
      first_w = mem[first_idx];
      tick();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (buf_we) begin
            seen = 1'b1;
            n_chk++; if ({buf_addr, buf_data} !== {7'd0, first_w[7:0]})
               $display("FAIL ar_first_write: got addr %0d data %02h want addr 0 data %02h",
                        buf_addr, buf_data, first_w[7:0]);
            else n_pass++;
         end
      end
      n_chk++; if (!seen) $display("FAIL ar_restart: got no write want write within 20 cycles"); else n_pass++;
      wait_drain(40, ok);
      n_chk++; if (!ok || {pkt_valid, wr_bank} !== 3'b000)
         $display("FAIL ar_drain: got pending %0d valid %b bank %b want 0/00/0", sb.size(), pkt_valid, wr_bank);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_packet();
      test_back_pressure();
      test_timeout();
      test_flush();
      test_back_to_back();
      test_async_reset();
      n_chk++; if (rd_err != 0) $display("FAIL rd_on_empty: got %0d want 0", rd_err); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sample_usb_packer.md
Name: sample_usb_packer

Overview:
- Drains the SDRAM readback sample FIFO (16-bit words, clk_48 read side) and packs the words into USB bulk IN packets. Bytes are little-endian.
- Packets are written into a double-banked 2×64-byte region of the USB packet RAM. Each bank is reported to the IN-endpoint logic as a ready packet with its length.
- Replaces the per-word CPU polling of the readback FIFO with a hardware streaming path.
- Short packets are committed on an idle timeout or on an explicit flush.

Parameters:
- PKT_BYTES, 64, full packet size in bytes; must be even, range 2..64.
- TIMEOUT, 48000, clk_48 cycles of FIFO-empty with a partial packet before a forced commit (1 ms).
- TW, 16, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk_48  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new FIFO reads; a word already in flight always completes.
- flush  in  1  level; commit any partial packet when no word is in flight.
- fifo_rd  out  1  FIFO read strobe; data is valid the cycle after.
- fifo_rd_data  in  16  FIFO read data.
- fifo_empty  in  1  FIFO empty flag.
- buf_we  out  1  packet RAM byte write enable.
- buf_addr  out  7  {bank, byte_index[5:0]}.
- buf_data  out  8  byte to write.
- pkt_valid  out  2  per bank: packet committed, not yet released.
- pkt_len  out  14  {len_bank1[6:0], len_bank0[6:0]}, byte count 0..64.
- pkt_release  in  2  per-bank single-cycle pulse from the IN endpoint after a successful transfer.
- wr_bank  out  1  bank currently being filled.

Behaviour:
- Reset values: fifo_rd=0, buf_we=0, buf_addr=0, buf_data=0, pkt_valid=0, pkt_len=0, wr_bank=0. Internal state: ptr=0, idle_cnt=0, state=FETCH.
- ptr is a 7-bit byte pointer into the current bank.
- can_read = enable && !fifo_empty && !pkt_valid[wr_bank].
- FETCH state:
  - If can_read: fifo_rd=1 for one cycle, go to LO.
  - Else if ptr!=0 and (flush or idle_cnt==TIMEOUT-1): commit, stay in FETCH.
  - idle_cnt increments while ptr!=0 && fifo_empty; it clears on any fifo_rd or any commit.
- LO state: buf_we=1, buf_addr={wr_bank, ptr[5:0]}, buf_data=fifo_rd_data[7:0]. Latch fifo_rd_data[15:8]. Go to HI.
- HI state: buf_we=1, buf_addr={wr_bank, ptr[5:0]+1}, buf_data=latched high byte. Then ptr+=2.
  - If ptr+2==PKT_BYTES: commit, go to FETCH.
  - Else if can_read: fifo_rd=1, go to LO (back-to-back throughput is 2 cycles per word).
  - Else go to FETCH.
- Commit:
  - pkt_valid[wr_bank]<=1.
  - The length field for wr_bank <= number of bytes written (ptr+2 on a full packet, ptr on a timeout or flush).
  - wr_bank<=~wr_bank, ptr<=0, idle_cnt<=0.
- pkt_release[b] clears pkt_valid[b] on the next edge. pkt_len is not cleared.
- Release of a bank that is not valid is ignored.
- Release and commit in the same cycle affect distinct bits. A commit targets wr_bank, which is never valid at that moment.
- Both banks full: can_read=0. No reads are issued, and the FIFO back-pressures upstream.
- Timeout never commits an empty packet (ptr==0). Zero-length-packet policy belongs to the endpoint logic.
- enable deasserted mid-word: LO/HI still complete. Partial-packet timeout/flush still operates.
- fifo_empty asserted together with fifo_rd: forbidden by construction, because fifo_rd requires !fifo_empty in the same cycle.
- Asynchronous reset mid-packet: all state returns to its reset values. The partial bank content is discarded.

Decomposition:
- Shared package holds:
  - state encoding: FETCH=2'd0, LO=2'd1, HI=2'd2.
  - USB_PKT_MAX=64.
  - the pkt_len field-slice helper: bank b occupies bits [7b+6:7b].
- The timeout counter is a natural small sub-module, idle_timer: clk_48, rst_n, run, clr, expired.
- The rest stays in one module.

Test Plan:
- 32 words 0x0100..0x011F preloaded, enable=1:
  - buf_data sequence is 00,01,01,01,...,1F,01 at addresses 0..63 of bank 0.
  - pkt_valid=2'b01, len0=64, wr_bank=1.
  - fifo_rd pulses exactly 2 cycles apart.
- 70 words, no release:
  - banks 0 and 1 both valid, each len=64.
  - fifo_rd stays low with 6 words still in the FIFO.
  - pulse pkt_release=2'b01: reading resumes into bank 0.
- 3 words, then FIFO stays empty, TIMEOUT=100:
  - commit exactly 100 cycles after the last fifo_rd-induced clear.
  - len0=6, pkt_valid[0]=1.
- 1 word, flush=1 in FETCH:
  - commit next edge with len=2.
  - flush with ptr==0: pkt_valid is unchanged.
- Release bank 1 in the same cycle that bank 0 commits:
  - pkt_valid goes 2'b10 -> 2'b01.
  - wr_bank=1, and filling of bank 1 starts.
- Assert rst_n=0 in LO state of word 5:
  - all outputs return to zero immediately (asynchronously).
  - after release from reset, the next word writes bank 0, byte 0.
